// File: rtl/mem_if_pkg.sv
// mem_if_pkg
//   Shared types and defaults for the mem_if_ctrl memory interface controller.
//   - mem_if_state_e : controller FSM states
//   - op_e           : operation latched when a command is accepted
//   - DEF_*          : default parameter values
//   - lane_bits()    : width of the read-lane index (at least 1 bit)
package mem_if_pkg;

    localparam int unsigned DEF_ADDR_W  = 14;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_OP_W    = 8;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } mem_if_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // A single-lane word still gets a 1-bit index so no port collapses to zero width.
    function automatic int unsigned lane_bits(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/mem_if_lane_sel.sv
// mem_if_lane_sel
//   Read-lane multiplexer: picks operand lane lane_i (OP_W bits) out of a
//   DATA_W-bit memory word. Lane indices past the last lane return zero.
//   Ports:
//     data_i  in  DATA_W  memory word
//     lane_i  in  LANE_W  lane index
//     op_o    out OP_W    selected operand
module mem_if_lane_sel
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OP_W   = DEF_OP_W,
    localparam int unsigned LANES  = DATA_W / OP_W,
    localparam int unsigned LANE_W = lane_bits(LANES)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic [OP_W-1:0]   op_o
);

    always_comb begin
        op_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_i == LANE_W'(i)) begin
                op_o = data_i[i*OP_W +: OP_W];
            end
        end
    end

endmodule

// File: rtl/mem_if_ctrl.sv
// mem_if_ctrl
//   Memory interface controller between the instruction unit and the memory
//   subsystem. Converts level-held load/store commands into a single
//   outstanding read/write request, selects the addressed operand lane on
//   reads and pulses mem_done on completion.
//   Optional feature macro: MEM_IF_TIMEOUT_EN -- a WAIT-state response
//   timeout that completes the transaction with mem_err alongside mem_done.
//   Ports:
//     clk          in   clock
//     reset_n      in   asynchronous active-low reset
//     load/store   in   read/write commands, held until mem_done
//     addr         in   ADDR_W operand address
//     result       in   DATA_W write data
//     mem_resp     in   memory response/acknowledge
//     datafrommem  in   DATA_W read data, valid with mem_resp
//     read_req     out  read request
//     write_req    out  write request
//     cs           out  chip select (read_req | write_req)
//     addrout      out  ADDR_W latched address
//     datatomem    out  DATA_W latched write data
//     datatoinst   out  OP_W selected read operand
//     mem_done     out  one-cycle completion pulse
//     mem_err      out  one-cycle timeout pulse (coincident with mem_done)
module mem_if_ctrl
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned OP_W    = DEF_OP_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] result,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] datafrommem,
    output logic              read_req,
    output logic              write_req,
    output logic              cs,
    output logic [ADDR_W-1:0] addrout,
    output logic [DATA_W-1:0] datatomem,
    output logic [OP_W-1:0]   datatoinst,
    output logic              mem_done,
    output logic              mem_err
);

    localparam int unsigned LANES  = DATA_W / OP_W;
    localparam int unsigned LANE_W = lane_bits(LANES);

    mem_if_state_e     state_q;
    op_e               op_q;
    logic              read_req_q;
    logic              write_req_q;
    logic [ADDR_W-1:0] addrout_q;
    logic [DATA_W-1:0] datatomem_q;
    logic [OP_W-1:0]   datatoinst_q;
    logic              mem_done_q;

    logic [LANE_W-1:0] lane;
    logic [OP_W-1:0]   lane_data;

    // Lane comes from the latched address so addr changes during WAIT are ignored.
    if (LANES > 1) begin : g_lane
        assign lane = addrout_q[LANE_W-1:0];
    end else begin : g_no_lane
        assign lane = '0;
    end

    mem_if_lane_sel #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_lane_sel (
        .data_i (datafrommem),
        .lane_i (lane),
        .op_o   (lane_data)
    );

`ifdef MEM_IF_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             mem_err_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            read_req_q   <= 1'b0;
            write_req_q  <= 1'b0;
            addrout_q    <= '0;
            datatomem_q  <= '0;
            datatoinst_q <= '0;
            mem_done_q   <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
            wait_cnt_q   <= '0;
            mem_err_q    <= 1'b0;
`endif
        end else begin
            mem_done_q <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
            mem_err_q  <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (load || store) begin
                        addrout_q <= addr;
                        if (load) begin
                            op_q       <= OP_READ;
                            read_req_q <= 1'b1;
                        end else begin
                            op_q        <= OP_WRITE;
                            write_req_q <= 1'b1;
                            datatomem_q <= result;
                        end
`ifdef MEM_IF_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Response has priority over a timeout on the same edge.
                    if (mem_resp) begin
                        read_req_q  <= 1'b0;
                        write_req_q <= 1'b0;
                        if (op_q == OP_READ) begin
                            datatoinst_q <= lane_data;
                        end
                        mem_done_q <= 1'b1;
                        state_q    <= DONE;
                    end
`ifdef MEM_IF_TIMEOUT_EN
                    // Counter reaches TIMEOUT on this edge: this is the TIMEOUT-th WAIT cycle.
                    else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        read_req_q  <= 1'b0;
                        write_req_q <= 1'b0;
                        mem_done_q  <= 1'b1;
                        mem_err_q   <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!load && !store) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_req   = read_req_q;
    assign write_req  = write_req_q;
    assign cs         = read_req_q | write_req_q;
    assign addrout    = addrout_q;
    assign datatomem  = datatomem_q;
    assign datatoinst = datatoinst_q;
    assign mem_done   = mem_done_q;
`ifdef MEM_IF_TIMEOUT_EN
    assign mem_err    = mem_err_q;
`else
    assign mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_if_ctrl.sv
// tb_mem_if_ctrl
//   Directed testbench for mem_if_ctrl. Inputs are driven 1 time unit after
//   the rising edge and outputs are sampled at the same point. Timeout
//   scenarios are compiled only when MEM_IF_TIMEOUT_EN is defined.
module tb_mem_if_ctrl;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              load;
    logic              store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] result;
    logic              mem_resp;
    logic [DATA_W-1:0] datafrommem;
    logic              read_req;
    logic              write_req;
    logic              cs;
    logic [ADDR_W-1:0] addrout;
    logic [DATA_W-1:0] datatomem;
    logic [OP_W-1:0]   datatoinst;
    logic              mem_done;
    logic              mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_if_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .OP_W    (OP_W),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .store       (store),
        .addr        (addr),
        .result      (result),
        .mem_resp    (mem_resp),
        .datafrommem (datafrommem),
        .read_req    (read_req),
        .write_req   (write_req),
        .cs          (cs),
        .addrout     (addrout),
        .datatomem   (datatomem),
        .datatoinst  (datatoinst),
        .mem_done    (mem_done),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load = 1'b0; store = 1'b0; addr = '0; result = '0;
        mem_resp = 1'b0; datafrommem = '0;
        tick(); tick();
        n_checks++;
        if ({read_req, write_req, cs, addrout, datatomem, datatoinst, mem_done, mem_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rr=%b wr=%b cs=%b ao=%h dtm=%h dti=%h done=%b err=%b, want all 0",
                     read_req, write_req, cs, addrout, datatomem, datatoinst, mem_done, mem_err);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (read_req !== 1'b0 || mem_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: rr=%b done=%b, want 0 0", read_req, mem_done);
        end
    endtask

    // Lane 1 read, response after 3 WAIT cycles; addr changes mid-WAIT are ignored.
    task automatic test_read();
        int high_cycles = 0;
        load = 1'b1; addr = 14'h0101; datafrommem = 16'hBEEF;
        tick();
        n_checks++;
        if (read_req !== 1'b1 || cs !== 1'b1 || write_req !== 1'b0 || addrout !== 14'h0101) begin
            n_fail++;
            $display("FAIL read_issue: rr=%b cs=%b wr=%b ao=%h, want 1 1 0 0101", read_req, cs, write_req, addrout);
        end
        if (read_req === 1'b1) high_cycles++;
        addr = 14'h0000;
        tick();
        if (read_req === 1'b1) high_cycles++;
        tick();
        if (read_req === 1'b1) high_cycles++;
        n_checks++;
        if (addrout !== 14'h0101 || mem_done !== 1'b0) begin
            n_fail++;
            $display("FAIL read_hold: ao=%h done=%b, want 0101 0", addrout, mem_done);
        end
        mem_resp = 1'b1;
        tick();
        if (read_req === 1'b1) high_cycles++;
        n_checks++;
        if (high_cycles != 3) begin
            n_fail++;
            $display("FAIL read_req_cycles: got %0d, want 3", high_cycles);
        end
        n_checks++;
        if (read_req !== 1'b0 || cs !== 1'b0 || datatoinst !== 8'hBE || mem_done !== 1'b1 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_complete: rr=%b cs=%b dti=%h done=%b err=%b, want 0 0 BE 1 0",
                     read_req, cs, datatoinst, mem_done, mem_err);
        end
        mem_resp = 1'b0; load = 1'b0;
        tick();
        n_checks++;
        if (mem_done !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done_pulse: done=%b, want 0", mem_done);
        end
        tick();
    endtask

    task automatic test_store();
        store = 1'b1; addr = 14'h3FFE; result = 16'h1234;
        tick();
        n_checks++;
        if (write_req !== 1'b1 || cs !== 1'b1 || read_req !== 1'b0 || addrout !== 14'h3FFE || datatomem !== 16'h1234) begin
            n_fail++;
            $display("FAIL store_issue: wr=%b cs=%b rr=%b ao=%h dtm=%h, want 1 1 0 3FFE 1234",
                     write_req, cs, read_req, addrout, datatomem);
        end
        result = 16'hFFFF;
        tick();
        n_checks++;
        if (datatomem !== 16'h1234 || write_req !== 1'b1) begin
            n_fail++;
            $display("FAIL store_hold: dtm=%h wr=%b, want 1234 1", datatomem, write_req);
        end
        mem_resp = 1'b1; datafrommem = 16'h5555;
        tick();
        n_checks++;
        if (write_req !== 1'b0 || cs !== 1'b0 || mem_done !== 1'b1 || datatoinst !== 8'hBE || datatomem !== 16'h1234) begin
            n_fail++;
            $display("FAIL store_complete: wr=%b cs=%b done=%b dti=%h dtm=%h, want 0 0 1 BE 1234",
                     write_req, cs, mem_done, datatoinst, datatomem);
        end
        mem_resp = 1'b0; store = 1'b0;
        tick(); tick();
    endtask

    // Lane 0 read with mem_resp already high: ignored in IDLE, done 2 cycles after command.
    task automatic test_min_latency();
        load = 1'b1; addr = 14'h0100; datafrommem = 16'hBEEF; mem_resp = 1'b1;
        tick();
        n_checks++;
        if (read_req !== 1'b1 || mem_done !== 1'b0) begin
            n_fail++;
            $display("FAIL minlat_issue: rr=%b done=%b, want 1 0", read_req, mem_done);
        end
        tick();
        n_checks++;
        if (read_req !== 1'b0 || mem_done !== 1'b1 || datatoinst !== 8'hEF) begin
            n_fail++;
            $display("FAIL minlat_done: rr=%b done=%b dti=%h, want 0 1 EF", read_req, mem_done, datatoinst);
        end
        // Response held high for several cycles counts once.
        tick();
        n_checks++;
        if (mem_done !== 1'b0 || read_req !== 1'b0) begin
            n_fail++;
            $display("FAIL minlat_single: done=%b rr=%b, want 0 0", mem_done, read_req);
        end
        mem_resp = 1'b0; load = 1'b0;
        tick(); tick();
    endtask

    task automatic test_load_store_both();
        int extra = 0;
        load = 1'b1; store = 1'b1; addr = 14'h0002; result = 16'hAAAA; datafrommem = 16'h1234;
        tick();
        n_checks++;
        if (read_req !== 1'b1 || write_req !== 1'b0 || datatomem !== 16'h1234) begin
            n_fail++;
            $display("FAIL both_priority: rr=%b wr=%b dtm=%h, want 1 0 1234", read_req, write_req, datatomem);
        end
        mem_resp = 1'b1;
        tick();
        n_checks++;
        if (mem_done !== 1'b1 || datatoinst !== 8'h34) begin
            n_fail++;
            $display("FAIL both_done: done=%b dti=%h, want 1 34", mem_done, datatoinst);
        end
        mem_resp = 1'b0; store = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (read_req !== 1'b0 || write_req !== 1'b0 || mem_done !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL held_no_reissue: %0d cycles with activity, want 0", extra);
        end
        load = 1'b0;
        tick();
        load = 1'b1;
        tick();
        n_checks++;
        if (read_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reissue_after_release: rr=%b, want 1", read_req);
        end
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0; load = 1'b0;
        tick(); tick();
    endtask

`ifdef MEM_IF_TIMEOUT_EN
    task automatic test_timeout();
        int high_cycles = 0;
        load = 1'b1; addr = 14'h0001; datafrommem = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (read_req === 1'b1) high_cycles++;
            if (mem_done === 1'b1) break;
        end
        n_checks++;
        if (high_cycles != 4) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got %0d, want 4", high_cycles);
        end
        n_checks++;
        if (mem_done !== 1'b1 || mem_err !== 1'b1 || read_req !== 1'b0 || datatoinst !== 8'h34) begin
            n_fail++;
            $display("FAIL timeout_err: done=%b err=%b rr=%b dti=%h, want 1 1 0 34", mem_done, mem_err, read_req, datatoinst);
        end
        load = 1'b0;
        tick();
        n_checks++;
        if (mem_done !== 1'b0 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: done=%b err=%b, want 0 0", mem_done, mem_err);
        end
        tick();
    endtask

    task automatic test_timeout_race();
        load = 1'b1; addr = 14'h0000; datafrommem = 16'h00C3;
        tick(); tick(); tick(); tick();
        mem_resp = 1'b1;
        tick();
        n_checks++;
        if (mem_done !== 1'b1 || mem_err !== 1'b0 || datatoinst !== 8'hC3) begin
            n_fail++;
            $display("FAIL timeout_race: done=%b err=%b dti=%h, want 1 0 C3", mem_done, mem_err, datatoinst);
        end
        mem_resp = 1'b0; load = 1'b0;
        tick(); tick();
    endtask
`else
    task automatic test_no_timeout();
        int low = 0;
        load = 1'b1; addr = 14'h0000; datafrommem = 16'h00C3;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (read_req !== 1'b1 || mem_done !== 1'b0 || mem_err !== 1'b0) low++;
        end
        n_checks++;
        if (low != 0) begin
            n_fail++;
            $display("FAIL no_timeout_wait: %0d cycles left WAIT, want 0", low);
        end
        mem_resp = 1'b1;
        tick();
        n_checks++;
        if (mem_done !== 1'b1 || mem_err !== 1'b0 || datatoinst !== 8'hC3) begin
            n_fail++;
            $display("FAIL no_timeout_done: done=%b err=%b dti=%h, want 1 0 C3", mem_done, mem_err, datatoinst);
        end
        mem_resp = 1'b0; load = 1'b0;
        tick(); tick();
    endtask
`endif

    task automatic test_reset_mid_wait();
        int done_seen = 0;
        load = 1'b1; addr = 14'h0055;
        tick();
        n_checks++;
        if (read_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_issue: rr=%b, want 1", read_req);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({read_req, write_req, cs, addrout, datatomem, datatoinst, mem_done, mem_err} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: rr=%b cs=%b ao=%h dtm=%h dti=%h done=%b, want all 0",
                     read_req, cs, addrout, datatomem, datatoinst, mem_done);
        end
        mem_resp = 1'b1;
        tick();
        if (mem_done === 1'b1) done_seen++;
        reset_n = 1'b1; load = 1'b0;
        tick();
        if (mem_done === 1'b1) done_seen++;
        n_checks++;
        if (done_seen != 0 || read_req !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: done seen %0d rr=%b, want 0 0", done_seen, read_req);
        end
        mem_resp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_store();
        test_min_latency();
        test_load_store_both();
`ifdef MEM_IF_TIMEOUT_EN
        test_timeout();
        test_timeout_race();
`else
        test_no_timeout();
`endif
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_if_ctrl.md
# mem_if_ctrl

Parametrised memory interface controller between the instruction unit and the system memory subsystem (MSS). It turns level-held `load`/`store` commands into single-outstanding read/write requests with a clean request/response handshake. It selects the addressed operand lane on reads and reports completion with a one-cycle `mem_done` pulse. An optional response timeout reports a hung memory as an error instead of stalling the core.

## Interface
Parameters:
- `ADDR_W`, 14: memory address width (16 KB space).
- `DATA_W`, 16: memory word width.
- `OP_W`, 8: operand width returned to the instruction unit; `DATA_W` must be an integer multiple of `OP_W`.
- `TIMEOUT`, 255: WAIT cycles before timeout; used only with `MEM_IF_TIMEOUT_EN`; must be at least 1.

Ports:
- `clk` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `load` in 1: read command from the instruction unit, held until `mem_done`.
- `store` in 1: write command, held until `mem_done`.
- `addr` in `ADDR_W`: operand address.
- `result` in `DATA_W`: write data.
- `mem_resp` in 1: MSS response/acknowledge.
- `datafrommem` in `DATA_W`: MSS read data, valid while `mem_resp` is high.
- `read_req` out 1: read request to the MSS.
- `write_req` out 1: write request to the MSS.
- `cs` out 1: chip select, equal to `read_req | write_req`.
- `addrout` out `ADDR_W`: address to the MSS.
- `datatomem` out `DATA_W`: write data to the MSS.
- `datatoinst` out `OP_W`: selected read operand.
- `mem_done` out 1: one-cycle completion pulse.
- `mem_err` out 1: one-cycle timeout pulse, coincident with `mem_done`.

## Operation
- States: IDLE, WAIT, DONE, RELEASE.
- **Reset.** The block enters IDLE and clears every output: `read_req`, `write_req`, `cs`, `addrout`, `datatomem`, `datatoinst`, `mem_done`, `mem_err`.
- **IDLE.** If `load` or `store` is high, the block latches `addrout <= addr` and raises the matching request, then moves to WAIT. On a store it also latches `datatomem <= result`.
  - If both are high, `load` wins.
  - `mem_resp` is ignored in IDLE.
- **WAIT.** The request stays asserted and `addrout`/`datatomem` are held stable.
  - When `mem_resp` is sampled high, the request is dropped and the block moves to DONE.
  - On a read, that same edge captures `datatoinst <= datafrommem[lane*OP_W +: OP_W]`, where `lane = addr[$clog2(DATA_W/OP_W)-1:0]`. With `DATA_W == OP_W`, lane is 0.
  - On a write, `datatoinst` is unchanged.
- **DONE.** `mem_done = 1` for exactly one cycle, then the block moves to RELEASE.
- **RELEASE.** The block waits until `load` and `store` are both low, then returns to IDLE. This prevents a held command from re-issuing.
- Only one request is outstanding at a time. `load`/`store` changes during WAIT are ignored.
- Reset asserted mid-transaction drops the request immediately and asynchronously; no `mem_done` is produced.

## Timing
- The command sampled high at edge N produces `read_req`/`write_req`/`cs` high in cycle N+1.
- `mem_resp` sampled high at edge M produces, from M onward:
  - request low;
  - `datatoinst` valid;
  - `mem_done` high for the single cycle M to M+1.
- Minimum transaction latency, command to `mem_done`, is 2 cycles, with `mem_resp` already high in the first WAIT cycle.
- Back-to-back transactions require at least one cycle with both commands low.
- `mem_resp` high for several cycles is treated as a single response.

## Configuration
- `MEM_IF_TIMEOUT_EN` defined:
  - A WAIT-cycle counter, `$clog2(TIMEOUT+1)` bits wide, is cleared on entry to WAIT.
  - When the counter reaches `TIMEOUT` with no `mem_resp`, the request is dropped and the block moves to DONE with `mem_err = 1` alongside `mem_done`. `datatoinst` is unchanged.
  - If `mem_resp` arrives on the same edge as the timeout, the response wins and `mem_err` stays 0.
- Not defined: WAIT lasts indefinitely, there is no counter, and `mem_err` is tied to 0.

## Structure
- Package `mem_if_pkg`:
  - `mem_if_state_e` enum (IDLE, WAIT, DONE, RELEASE);
  - `op_e` (OP_READ, OP_WRITE), the latched operation;
  - default values for `ADDR_W`, `DATA_W`, `OP_W` and `TIMEOUT`.
- Sub-module `mem_if_lane_sel`, a parametrised read-lane multiplexer (`DATA_W`, `OP_W`); it is instantiated once.

## Test plan
- Reset mid-WAIT, with `read_req = 1` → all outputs go to 0 asynchronously, the state is IDLE, and no `mem_done` is produced.
- Read, `addr = 14'h0101`, `datafrommem = 16'hBEEF`, `mem_resp` after 3 WAIT cycles → `addrout = 14'h0101`, `read_req` high for 3 cycles, `datatoinst = 8'hBE`, `mem_done` high for 1 cycle.
- Store, `addr = 14'h3FFE`, `result = 16'h1234` → `write_req`/`cs` high, `datatomem = 16'h1234` stable until `mem_resp`, `mem_done` pulse, `datatoinst` unchanged.
- `load` and `store` high together, with `load` held 5 cycles after `mem_done` → exactly one read and no re-issue until `load` drops for at least 1 cycle.
- `MEM_IF_TIMEOUT_EN` with `TIMEOUT = 4` and no `mem_resp` → request drops after 4 WAIT cycles, then `mem_done = mem_err = 1` for 1 cycle.
- `MEM_IF_TIMEOUT_EN` with `mem_resp` arriving on the timeout edge → normal completion with `mem_err = 0`.
